// File: rtl/up3.sv
// up3 -- binary (bitnet) 1-to-3 expansion layer.
//
// Each of N input bits fans out to three output bits through three learned
// 1-bit weights (XNOR binding), giving OUT_N = 3*N outputs. The backward pass
// maps 3N targets to N desired inputs by a per-unit majority vote. It then
// flips, gated by the oscillator bit, every weight whose target disagrees
// with the last forward output.
//
// Unit i owns w[3i+2:3i], fin[i], bin[3i+2:3i], fout[3i+2:3i], bout[i].
//
// Ports:
//   clk_in        clock
//   rst_in        asynchronous active-low reset
//   oscillator    random bit, gates the backward weight update
//   fd_prop       start forward pass (level, sampled in IDLE; wins over bk_prop)
//   bk_prop       start backward pass (level, sampled in IDLE)
//   fin  [N]      forward input bits
//   bin  [3N]     backward target bits
//   fd_prop_done  one-cycle pulse, forward pass complete
//   bk_prop_done  one-cycle pulse, backward pass complete
//   busy          high while not IDLE
//   control_out   current weight register w
//   fout [3N]     forward output (held between passes)
//   bout [N]      backward output / desired input (held between passes)
//
// Optional feature, macro UP3_WEIGHT_LOAD_EN:
//   load_en       in IDLE with no command pending, loads w from load_data
//   load_data [3N]
module up3 #(
  parameter int N = 9
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           oscillator,
  input  logic           fd_prop,
  input  logic           bk_prop,
  input  logic [N-1:0]   fin,
  input  logic [3*N-1:0] bin,
`ifdef UP3_WEIGHT_LOAD_EN
  input  logic           load_en,
  input  logic [3*N-1:0] load_data,
`endif
  output logic           fd_prop_done,
  output logic           bk_prop_done,
  output logic           busy,
  output logic [3*N-1:0] control_out,
  output logic [3*N-1:0] fout,
  output logic [N-1:0]   bout
);

  localparam int OUT_N = 3 * N;

  typedef enum logic [2:0] {
    IDLE,
    FWD_CALC,
    FWD_DONE,
    BK_CALC,
    BK_UPD
  } state_t;

  state_t           state;
  logic [OUT_N-1:0] w;
  logic [N-1:0]     fin_q;
  logic [OUT_N-1:0] bin_q;

  logic [OUT_N-1:0] fin_x;     // each latched input bit replicated across its unit
  logic [OUT_N-1:0] fwd_nxt;
  logic [OUT_N-1:0] agree;     // target bit agrees with its weight
  logic [N-1:0]     bk_nxt;

  always_comb begin
    fin_x  = '0;
    bk_nxt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      fin_x[3*i +: 3] = {3{fin_q[i]}};
    end
    fwd_nxt = ~(fin_x ^ w);
    agree   = ~(bin_q ^ w);
    for (int unsigned i = 0; i < N; i++) begin
      bk_nxt[i] = (agree[3*i] & agree[3*i+1]) |
                  (agree[3*i] & agree[3*i+2]) |
                  (agree[3*i+1] & agree[3*i+2]);
    end
  end

  assign control_out = w;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state        <= IDLE;
      w            <= '0;
      fin_q        <= '0;
      bin_q        <= '0;
      fout         <= '0;
      bout         <= '0;
      fd_prop_done <= 1'b0;
      bk_prop_done <= 1'b0;
      busy         <= 1'b0;
    end else begin
      fd_prop_done <= 1'b0;
      bk_prop_done <= 1'b0;
      case (state)
        IDLE: begin
          if (fd_prop) begin
            fin_q <= fin;
            state <= FWD_CALC;
            busy  <= 1'b1;
          end else if (bk_prop) begin
            bin_q <= bin;
            state <= BK_CALC;
            busy  <= 1'b1;
          end
`ifdef UP3_WEIGHT_LOAD_EN
          else if (load_en) begin
            w <= load_data;
          end
`endif
        end
        FWD_CALC: begin
          fout  <= fwd_nxt;
          state <= FWD_DONE;
        end
        FWD_DONE: begin
          fd_prop_done <= 1'b1;
          state        <= IDLE;
          busy         <= 1'b0;
        end
        BK_CALC: begin
          // Majority uses the weights as they stand before this pass's update.
          bout  <= bk_nxt;
          state <= BK_UPD;
        end
        BK_UPD: begin
          // Flip every weight whose target disagrees with the held forward output.
          if (oscillator) begin
            w <= w ^ (bin_q ^ fout);
          end
          bk_prop_done <= 1'b1;
          state        <= IDLE;
          busy         <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_up3.sv
module tb_up3;

  localparam int N = 3;

  logic           clk_in = 1'b0;
  logic           rst_in = 1'b0;
  logic           oscillator = 1'b0;
  logic           fd_prop = 1'b0;
  logic           bk_prop = 1'b0;
  logic [N-1:0]   fin = '0;
  logic [3*N-1:0] bin = '0;
`ifdef UP3_WEIGHT_LOAD_EN
  logic           load_en = 1'b0;
  logic [3*N-1:0] load_data = '0;
`endif
  logic           fd_prop_done;
  logic           bk_prop_done;
  logic           busy;
  logic [3*N-1:0] control_out;
  logic [3*N-1:0] fout;
  logic [N-1:0]   bout;

  up3 #(.N(N)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .oscillator  (oscillator),
    .fd_prop     (fd_prop),
    .bk_prop     (bk_prop),
    .fin         (fin),
    .bin         (bin),
`ifdef UP3_WEIGHT_LOAD_EN
    .load_en     (load_en),
    .load_data   (load_data),
`endif
    .fd_prop_done(fd_prop_done),
    .bk_prop_done(bk_prop_done),
    .busy        (busy),
    .control_out (control_out),
    .fout        (fout),
    .bout        (bout)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [1:0]     kind;   // {fd_prop_done, bk_prop_done}
    logic [3*N-1:0] fout;
    logic [N-1:0]   bout;
    logic [3*N-1:0] w;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse pops one expectation and checks the result.
  always @(negedge clk_in) begin
    if (fd_prop_done || bk_prop_done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got fd=%0b bk=%0b expected no pulse at %0t",
                 fd_prop_done, bk_prop_done, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_kind", {30'd0, fd_prop_done, bk_prop_done}, {30'd0, e.kind});
        check("fout", {23'd0, fout}, {23'd0, e.fout});
        check("bout", {29'd0, bout}, {29'd0, e.bout});
        check("control_out", {23'd0, control_out}, {23'd0, e.w});
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_fout"}, {23'd0, fout}, 32'd0);
    check({tag, "_bout"}, {29'd0, bout}, 32'd0);
    check({tag, "_control_out"}, {23'd0, control_out}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_dones"}, {30'd0, fd_prop_done, bk_prop_done}, 32'd0);
  endtask

  // Issue a command, push its expectation, check busy, latency and pulse width.
  task automatic run_pass(input logic do_fd, input logic do_bk,
                          input logic [N-1:0] f, input logic [3*N-1:0] b,
                          input logic osc, input logic disturb,
                          input logic [1:0] ekind, input logic [3*N-1:0] efout,
                          input logic [N-1:0] ebout, input logic [3*N-1:0] ew);
    exp_t e;
    int   lat;
    e.kind = ekind; e.fout = efout; e.bout = ebout; e.w = ew;
    sb.push_back(e);
    @(negedge clk_in);
    fin = f; bin = b; oscillator = osc;
    fd_prop = do_fd; bk_prop = do_bk;
    @(posedge clk_in);
    #1 check("busy_after_E0", {31'd0, busy}, 32'd1);
    lat = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk_in);
      if (c == 1) begin
        fd_prop = disturb; bk_prop = disturb;
      end else if (c == 2) begin
        fd_prop = 1'b0; bk_prop = 1'b0;
      end
      if (c == 2) check("busy_after_E1", {31'd0, busy}, 32'd1);
      if (fd_prop_done || bk_prop_done) lat = c;
    end
    check("done_latency", lat, 32'd3);
    check("busy_after_E2", {31'd0, busy}, 32'd0);
    @(negedge clk_in);
    check("done_cleared_E3", {30'd0, fd_prop_done, bk_prop_done}, 32'd0);
    oscillator = 1'b0;
  endtask

  initial begin
    rst_in = 1'b0;
    #1 check_reset_state("reset_initial");
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;

    // fin=101, w=0 -> fout = ~fin replicated
    run_pass(1'b1, 1'b0, 3'b101, 9'd0, 1'b0, 1'b0,
             2'b10, 9'b000_111_000, 3'b000, 9'b000_000_000);
    // backward with update
    run_pass(1'b0, 1'b1, 3'b000, 9'b000_111_111, 1'b1, 1'b0,
             2'b01, 9'b000_111_000, 3'b100, 9'b000_000_111);
    // forward with nonzero weights
    run_pass(1'b1, 1'b0, 3'b011, 9'd0, 1'b0, 1'b0,
             2'b10, 9'b111_000_111, 3'b100, 9'b000_000_111);
    // backward with mixed majority and update
    run_pass(1'b0, 1'b1, 3'b000, 9'b101_010_110, 1'b1, 1'b0,
             2'b01, 9'b111_000_111, 3'b011, 9'b010_010_110);

    // asynchronous reset mid-simulation, between clock edges
    @(posedge clk_in);
    #2 rst_in = 1'b0;
    #1 check_reset_state("reset_async");
    @(negedge clk_in);
    rst_in = 1'b1;

    // backward without update from w=0
    run_pass(1'b1, 1'b0, 3'b101, 9'd0, 1'b0, 1'b0,
             2'b10, 9'b000_111_000, 3'b000, 9'b000_000_000);
    run_pass(1'b0, 1'b1, 3'b000, 9'b000_111_111, 1'b0, 1'b0,
             2'b01, 9'b000_111_000, 3'b100, 9'b000_000_000);

    // fd and bk together: forward wins, bout and w untouched
    run_pass(1'b1, 1'b1, 3'b110, 9'h1FF, 1'b1, 1'b0,
             2'b10, 9'b000_000_111, 3'b100, 9'b000_000_000);
    // commands pulsed at E1 of a running pass: one done pulse only
    run_pass(1'b1, 1'b0, 3'b010, 9'd0, 1'b0, 1'b1,
             2'b10, 9'b111_000_111, 3'b100, 9'b000_000_000);
    repeat (4) @(negedge clk_in);

    // reset during FWD_CALC: no pulse, all state cleared
    fin = 3'b101; fd_prop = 1'b1;
    @(posedge clk_in);
    #2 fd_prop = 1'b0;
    rst_in = 1'b0;
    #1 check_reset_state("abort_fwd");
    @(posedge clk_in);
    @(posedge clk_in);
    rst_in = 1'b1;   // released on the edge the pulse would have occurred
    repeat (5) @(negedge clk_in);
    check("abort_fout", {23'd0, fout}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);

`ifdef UP3_WEIGHT_LOAD_EN
    @(negedge clk_in);
    load_en = 1'b1; load_data = 9'h1AB;
    @(posedge clk_in);
    #1 check("load_idle", {23'd0, control_out}, 32'h1AB);
    @(negedge clk_in);
    load_en = 1'b0;
    // load while busy must be ignored; fout = ~w = 9'h054 with fin=0
    fork
      run_pass(1'b1, 1'b0, 3'b000, 9'd0, 1'b0, 1'b0,
               2'b10, 9'h054, 3'b000, 9'h1AB);
      begin
        @(posedge clk_in);
        #2 load_en = 1'b1; load_data = 9'h000;
        @(negedge clk_in);
        @(negedge clk_in);
        load_en = 1'b0;
      end
    join
    check("load_busy_ignored", {23'd0, control_out}, 32'h1AB);
`endif

    repeat (3) @(negedge clk_in);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1);
  end

endmodule
